// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receive/transmit pair.
package uart_pkg;

    localparam int UART_DIV_W     = 13;
    localparam int UART_DATA_BITS = 8;

    localparam bit UART_PARITY_EVEN = 1'b0;
    localparam bit UART_PARITY_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } uart_rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// uart_sync: STAGES-deep bit synchroniser for asynchronous UART pins.
// Resets to 1 so an idle-high line never looks like a start or CTS edge.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '1;
        end else begin
            sync_ff[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_ff[i] <= sync_ff[i-1];
            end
        end
    end

    assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver, LSB-first, optional parity,
// one stop bit. Delivers each word with a single-cycle rx_valid pulse.
//
// state      | meaning
// IDLE       | line idle, waiting for rx_s low
// START      | half-bit wait, confirm start bit still low
// DATA       | sample DATA_BITS data bits, one per div_eff clocks
// PARITY     | sample parity bit
// STOP       | sample stop bit, publish word on the following clock
// BREAK_WAIT | stop bit was low, wait for line to return high
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int DIV_W       = UART_DIV_W,
    parameter int SYNC_STAGES = 2,
    parameter bit PARITY_ODD  = UART_PARITY_EVEN,
    parameter int MIN_DIV     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [DIV_W-1:0]     baud_rate,
    input  logic                 parity_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 busy
);

    localparam int               CNT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] ONE_DIV   = DIV_W'(1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

    uart_rx_state_e state_q, state_d;

    logic                 rx_s;
    logic [DIV_W-1:0]     div_eff;
    logic [DIV_W-1:0]     div_q;
    logic [DIV_W-1:0]     samp_cnt;
    logic                 samp_tc;
    logic                 par_en_q;
    logic                 par_bit;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 last_bit;
    logic [DATA_BITS-1:0] shreg;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign div_eff  = (baud_rate < MIN_DIV_V) ? MIN_DIV_V : baud_rate;
    assign samp_tc  = (samp_cnt <= ONE_DIV);
    assign last_bit = (bit_cnt == LAST_BIT);
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!rx_s) state_d = START;
            end
            START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (samp_tc) state_d = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (samp_tc && last_bit) state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (samp_tc) state_d = STOP;
            end
            STOP: begin
                if (samp_tc) state_d = rx_s ? IDLE : BREAK_WAIT;
            end
            BREAK_WAIT: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            par_en_q     <= 1'b0;
            samp_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        div_q    <= div_eff;
                        par_en_q <= parity_en;
                        bit_cnt  <= '0;
                        samp_cnt <= div_eff >> 1;
                    end
                end
                START, DATA, PARITY, STOP: begin
                    samp_cnt <= samp_tc ? div_q : samp_cnt - ONE_DIV;
                end
                default: ;
            endcase

            if (samp_tc) begin
                case (state_q)
                    DATA: begin
                        shreg[bit_cnt] <= rx_s;
                        bit_cnt        <= bit_cnt + ONE_CNT;
                    end
                    PARITY: begin
                        par_bit <= rx_s;
                    end
                    STOP: begin
                        // Word is delivered even when a flag is raised.
                        rx_valid     <= 1'b1;
                        rx_data      <= shreg;
                        frame_error  <= !rx_s;
                        parity_error <= par_en_q & (^shreg ^ par_bit ^ PARITY_ODD);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed and random UART frames, scoreboard checks
// data, error flags and rx_valid latency against a frame-level model.
module tb_uart_rx_core;

    localparam int SYNC    = 2;
    localparam int MIN_DIV = 4;
    localparam bit PODD    = 1'b0;

    logic        clk;
    logic        rst;
    logic        rx;
    logic [12:0] baud_rate;
    logic        parity_en;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_error;
    logic        parity_error;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] data;
        bit         fe;
        bit         pe;
        int         fall;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    uart_rx_core #(
        .DATA_BITS   (8),
        .DIV_W       (13),
        .SYNC_STAGES (SYNC),
        .PARITY_ODD  (PODD),
        .MIN_DIV     (MIN_DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .baud_rate    (baud_rate),
        .parity_en    (parity_en),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .frame_error  (frame_error),
        .parity_error (parity_error),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every rx_valid cycle consumes one expected frame.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got rx_valid=1 data=0x%0h required no pulse (cycle %0d)",
                         rx_data, cyc);
            end else begin
                int lat;
                mon_e = exp_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(mon_e.data));
                check("frame_error", 32'(frame_error), 32'(mon_e.fe));
                check("parity_error", 32'(parity_error), 32'(mon_e.pe));
                lat = cyc - mon_e.fall;
                total++;
                if (lat < mon_e.lat - 1 || lat > mon_e.lat + 1) begin
                    bad++;
                    $display("FAIL latency: got %0d clocks required %0d +/-1", lat, mon_e.lat);
                end
            end
        end
    end

    // Drives one frame starting at the current negedge; leaves rx at the stop level.
    task automatic send_frame(input logic [7:0] data, input int baud, input bit pen, input bit pbit,
                              input bit stop, input int stop_len, input int new_baud);
        int   div;
        exp_t e;
        div       = (baud < MIN_DIV) ? MIN_DIV : baud;
        baud_rate = 13'(baud);
        parity_en = pen;
        e.data = data;
        e.fe   = !stop;
        e.pe   = pen && ((($countones(data) + int'(pbit)) % 2) != int'(PODD));
        e.lat  = SYNC + div / 2 + (8 + int'(pen) + 1) * div + 1;
        rx     = 1'b0;
        e.fall = cyc;
        exp_q.push_back(e);
        repeat (div) @(negedge clk);
        if (new_baud > 0) baud_rate = 13'(new_baud);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (div) @(negedge clk);
        end
        if (pen) begin
            rx = pbit;
            repeat (div) @(negedge clk);
        end
        rx = stop;
        repeat (stop_len) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_data"}, 32'(rx_data), 32'h0);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
        check({tag, "_frame_error"}, 32'(frame_error), 32'h0);
        check({tag, "_parity_error"}, 32'(parity_error), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        int b;
        int d;
        rst       = 1'b1;
        rx        = 1'b1;
        baud_rate = 13'd16;
        parity_en = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(5);

        send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b1, 16, 0);
        idle(20);

        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 16, 0);
        idle(20);
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 16, 0);
        idle(20);

        // Stop bit low followed by a long break: one frame_error only.
        send_frame(8'h81, 16, 1'b0, 1'b0, 1'b0, 16, 0);
        repeat (200) @(negedge clk);
        check("break_busy_held", 32'(busy), 32'h1);
        idle(6);
        check("break_busy_released", 32'(busy), 32'h0);
        idle(10);

        // Three-clock glitch must be rejected at mid start bit.
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        check("glitch_busy_high", 32'(busy), 32'h1);
        repeat (9) @(negedge clk);
        check("glitch_busy_low", 32'(busy), 32'h0);
        idle(20);

        send_frame(8'h55, 2, 1'b0, 1'b0, 1'b1, 4, 0);
        idle(10);
        send_frame(8'h6A, 2, 1'b0, 1'b0, 1'b1, 4, 32);
        idle(20);

        // Back-to-back: second start begins just after the first stop midpoint.
        send_frame(8'h11, 16, 1'b0, 1'b0, 1'b1, 16 / 2 + 2, 0);
        send_frame(8'h22, 16, 1'b0, 1'b0, 1'b1, 16, 0);

        // Third frame aborted by reset during bit 4 (0xF3 bit 4 is 1).
        baud_rate = 13'd16;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d_bit(8'hF3, i);
            repeat (16) @(negedge clk);
        end
        rx = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midframe_rst");
        idle(300);

        for (int n = 0; n < 30; n++) begin
            b = int'($urandom_range(0, 20));
            d = (b < MIN_DIV) ? MIN_DIV : b;
            send_frame(8'($urandom), b, 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 5) != 0), d, 0);
            idle(4 + int'($urandom_range(0, 16)));
        end

        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL missing_valid: got %0d frames outstanding required 0", exp_q.size());
        end
        idle(50);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic d_bit(input logic [7:0] v, input int i);
        return v[i];
    endfunction

endmodule
